// File: rtl/mips_mem_responder.sv
// mips_mem_responder
//   Word-addressed RAM plus a small MMIO block (GPIO, TX byte FIFO, status and
//   an optional cycle counter) answering a MIPS-style data-memory port.
//   Reads are registered with one cycle of latency and return the
//   pre-write contents when a read and a write hit the same word.
//
// Optional feature (compile-time macro):
//   MIPS_MEM_RESP_CYCLE_CNT_EN - adds a 32-bit free-running cycle counter at
//   0xF000_000C. When undefined, that offset reads 0 and no counter exists.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  enable for all CPU-side state (RAM, GPIO, read data,
//                       FIFO pushes, status clear)
//   mem_write_en[3:0]   byte strobes, bit 3 = bits 31:24 (big-endian)
//   mem_read_en         read request
//   mem_addr[31:0]      byte address, [31:28]==4'hF selects MMIO
//   mem_write_data      lane-replicated write data
//   mem_read_data       registered read data
//   gpio_out            GPIO output register
//   tx_data, tx_valid   head byte of the TX FIFO / FIFO non-empty
//   tx_ready            consumer accepts the head byte (pop is independent of en)

module mips_mem_responder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_read_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Address decode and write strobes
    // ------------------------------------------------------------------
    logic              is_mmio;
    logic [25:0]       mmio_off;
    logic              sel_gpio, sel_tx, sel_stat;
    logic              wr_any;
    logic [31:0]       lane_mask;
    logic [ADDR_W-1:0] ram_idx;
    logic              unused_addr_lsb;

    assign is_mmio   = (mem_addr[31:28] == 4'hF);
    assign mmio_off  = mem_addr[27:2];
    assign sel_gpio  = is_mmio && (mmio_off == 26'd0);
    assign sel_tx    = is_mmio && (mmio_off == 26'd1);
    assign sel_stat  = is_mmio && (mmio_off == 26'd2);
    assign wr_any    = en && (mem_write_en != 4'b0000);
    assign lane_mask = {{8{mem_write_en[3]}}, {8{mem_write_en[2]}},
                        {8{mem_write_en[1]}}, {8{mem_write_en[0]}}};
    assign ram_idx   = mem_addr[ADDR_W+1:2];
    // Byte offset bits never affect lane selection; strobes do that.
    assign unused_addr_lsb = ^mem_addr[1:0];

    // ------------------------------------------------------------------
    // RAM (not reset). Read is a combinational tap sampled into the read
    // register on the same edge as the write, giving read-before-write.
    // ------------------------------------------------------------------
    logic [31:0] ram [2**ADDR_W];
    logic [31:0] ram_rdata;

    assign ram_rdata = ram[ram_idx];

    always_ff @(posedge clk) begin
        if (en && !is_mmio && (mem_write_en != 4'b0000)) begin
            ram[ram_idx] <= (ram[ram_idx] & ~lane_mask) | (mem_write_data & lane_mask);
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, pop, push_req, push_ok;
    logic [7:0]       push_byte;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo_mem[rd_ptr_q];
    assign pop      = tx_valid && tx_ready;
    assign push_req = wr_any && sel_tx;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok  = push_req && (!full || pop);

    // Byte on the lowest enabled strobe lane.
    always_comb begin
        push_byte = mem_write_data[31:24];
        if (mem_write_en[0])      push_byte = mem_write_data[7:0];
        else if (mem_write_en[1]) push_byte = mem_write_data[15:8];
        else if (mem_write_en[2]) push_byte = mem_write_data[23:16];
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
        // A dropped byte wins over a status-write clear in the same cycle.
        ovf_d = ovf_q;
        if (push_req && !push_ok)  ovf_d = 1'b1;
        else if (wr_any && sel_stat) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_byte;
        end
    end

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
`ifdef MIPS_MEM_RESP_CYCLE_CNT_EN
    logic        sel_cnt;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    assign sel_cnt = is_mmio && (mmio_off == 26'd3);

    // A lane load replaces the increment for that cycle; unwritten lanes hold.
    always_comb begin
        if (wr_any && sel_cnt) cyc_cnt_d = (cyc_cnt_q & ~lane_mask) | (mem_write_data & lane_mask);
        else                   cyc_cnt_d = cyc_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_cnt_q <= '0;
        else     cyc_cnt_q <= cyc_cnt_d;
    end
`endif

    // ------------------------------------------------------------------
    // GPIO and read data
    // ------------------------------------------------------------------
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] mmio_rdata;
    logic [31:0] mem_read_data_q, mem_read_data_d;

    always_comb begin
        mmio_rdata = 32'd0;
        if (sel_gpio)      mmio_rdata = gpio_q;
        else if (sel_stat) mmio_rdata = {29'd0, ovf_q, full, empty};
`ifdef MIPS_MEM_RESP_CYCLE_CNT_EN
        else if (sel_cnt)  mmio_rdata = cyc_cnt_q;
`endif
    end

    always_comb begin
        gpio_d = gpio_q;
        if (en && sel_gpio) gpio_d = (gpio_q & ~lane_mask) | (mem_write_data & lane_mask);
        mem_read_data_d = mem_read_data_q;
        if (en && mem_read_en) mem_read_data_d = is_mmio ? mmio_rdata : ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_data_q <= '0;
            gpio_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            ovf_q           <= 1'b0;
        end else begin
            mem_read_data_q <= mem_read_data_d;
            gpio_q          <= gpio_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            ovf_q           <= ovf_d;
        end
    end

    assign mem_read_data = mem_read_data_q;
    assign gpio_out      = gpio_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Testbench for mips_mem_responder: scoreboards for read data and TX bytes,
// plus direct checks of reset, hold and status behaviour.
module tb_mips_mem_responder;

    localparam logic [31:0] A_GPIO = 32'hF000_0000;
    localparam logic [31:0] A_TX   = 32'hF000_0004;
    localparam logic [31:0] A_STAT = 32'hF000_0008;
    localparam logic [31:0] A_CNT  = 32'hF000_000C;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  mem_write_en = 4'd0;
    logic        mem_read_en = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_write_data = 32'd0;
    logic [31:0] mem_read_data;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        rdy_v = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd_q[$];
    string       rd_tag_q[$];
    logic [7:0]  tx_q[$];

    mips_mem_responder #(.ADDR_W(10), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .gpio_out       (gpio_out),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle, driven at the falling edge. Reads queue their expected
    // value; TX pushes update the FIFO model (drop when full with no pop).
    task automatic drive(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                         input logic rd, input logic [31:0] exp, input string tag);
        logic [7:0] b;
        bit         found;
        @(negedge clk);
        en = 1'b1; mem_addr = addr; mem_write_en = we; mem_write_data = wd;
        mem_read_en = rd; tx_ready = rdy_v;
        if (rd) begin
            rd_q.push_back(exp);
            rd_tag_q.push_back(tag);
        end
        if (addr == A_TX && we != 4'd0) begin
            found = 0;
            b = 8'd0;
            for (int i = 0; i < 4; i++) begin
                if (!found && we[i]) begin
                    b = wd[8*i +: 8];
                    found = 1;
                end
            end
            if (tx_q.size() < DEPTH || (rdy_v && tx_q.size() > 0)) tx_q.push_back(b);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
        drive(addr, we, wd, 1'b0, 32'd0, "");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        drive(addr, 4'd0, 32'd0, 1'b1, exp, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_write_en = 4'd0; mem_read_en = 1'b0; tx_ready = rdy_v;
        end
    endtask

    // Read-data scoreboard: compare just after the edge that captured a read.
    always @(posedge clk) begin
        if (!rst && en && mem_read_en) begin
            #1;
            if (rd_q.size() == 0) check("rd_unexpected", mem_read_data, 32'hxxxx_xxxx);
            else check(rd_tag_q.pop_front(), mem_read_data, rd_q.pop_front());
        end
    end

    // TX scoreboard: a pop will occur at the next rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'hxxxx_xxxx);
            else check("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cnt_exp;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdata", mem_read_data, 32'd0);
        check("rst_gpio", gpio_out, 32'd0);
        check("rst_txvalid", {31'd0, tx_valid}, 32'd0);
        rst = 1'b0;
        rd(A_STAT, 32'd1, "rst_status");
        rd(A_GPIO, 32'd0, "rst_gpio_rd");

        // RAM lane writes, read latency, aliasing, read-before-write
        wr(32'h100, 4'hF, 32'h1122_3344);
        wr(32'h100, 4'b0010, 32'hAAAA_AAAA);
        wr(32'h200, 4'hF, 32'h0BAD_F00D);
        rd(32'h100, 32'h1122_AA44, "ram_byte_wr");
        repeat (3) begin
            @(negedge clk);
            en = 1'b0; mem_read_en = 1'b1; mem_addr = 32'h200;
            #1 check("hold_en0", mem_read_data, 32'h1122_AA44);
        end
        @(negedge clk);
        en = 1'b1; mem_read_en = 1'b0; mem_addr = 32'h200;
        @(posedge clk); #1;
        check("hold_noread", mem_read_data, 32'h1122_AA44);
        drive(32'h100, 4'hF, 32'h5566_7788, 1'b1, 32'h1122_AA44, "rbw_old");
        rd(32'h100, 32'h5566_7788, "rbw_new");
        rd(32'h100 + 32'h1000, 32'h5566_7788, "alias");
        rd(32'h200, 32'h0BAD_F00D, "ram_other");

        // GPIO and unmapped MMIO
        wr(A_GPIO, 4'hF, 32'hDEAD_BEEF);
        wr(A_GPIO, 4'b0001, 32'h1212_1212);
        rd(A_GPIO, 32'hDEAD_BE12, "gpio_lane");
        wr(A_GPIO, 4'b0001, 32'hEFEF_EFEF);
        wr(32'hF000_0010, 4'hF, 32'h1234_5678);
        rd(32'hF000_0010, 32'd0, "mmio_unmapped");
        rd(A_TX, 32'd0, "txdata_rd");
        idle(1);
        check("gpio_out", gpio_out, 32'hDEAD_BEEF);

        // FIFO overflow then drain
        rdy_v = 1'b0;
        wr(A_TX, 4'b0001, 32'h0101_0101);
        wr(A_TX, 4'b0001, 32'h0202_0202);
        wr(A_TX, 4'b0110, 32'hEEEE_03DD);
        wr(A_TX, 4'b1000, 32'h04FF_FFFF);
        wr(A_TX, 4'b0001, 32'h0505_0505);
        rd(A_STAT, 32'd6, "status_ovf_full");
        rdy_v = 1'b1;
        idle(8);
        check("tx_valid_drained", {31'd0, tx_valid}, 32'd0);
        check("tx_model_empty", tx_q.size(), 32'd0);
        rd(A_STAT, 32'd5, "status_ovf_sticky");
        wr(A_STAT, 4'b0001, 32'd0);
        rd(A_STAT, 32'd1, "status_clear");

        // Push while full with a simultaneous pop
        rdy_v = 1'b0;
        for (int i = 5; i <= 8; i++) wr(A_TX, 4'b0001, {4{8'(i)}});
        rdy_v = 1'b1;
        wr(A_TX, 4'b0001, 32'h0909_0909);
        idle(8);
        check("tx_model_empty2", tx_q.size(), 32'd0);
        rd(A_STAT, 32'd1, "status_no_ovf");

        // Cycle counter
        wr(A_CNT, 4'hF, 32'hFFFF_FFF0);
        for (int k = 0; k < 20; k++) begin
`ifdef MIPS_MEM_RESP_CYCLE_CNT_EN
            cnt_exp = 32'hFFFF_FFF0 + 32'(k);
`else
            cnt_exp = 32'd0;
`endif
            rd(A_CNT, cnt_exp, "cycle_cnt");
        end

        // Reset with FIFO holding 3 entries
        rdy_v = 1'b0;
        wr(A_TX, 4'b0001, 32'h3131_3131);
        wr(A_TX, 4'b0001, 32'h3232_3232);
        wr(A_TX, 4'b0001, 32'h3333_3333);
        idle(1);
        rd(A_STAT, 32'd0, "status_3");
        idle(1);
        check("pre_rst_gpio", gpio_out, 32'hDEAD_BEEF);
        #2 rst = 1'b1;
        tx_q.delete();
        #1;
        check("rst_async_txvalid", {31'd0, tx_valid}, 32'd0);
        check("rst_async_gpio", gpio_out, 32'd0);
        check("rst_async_rdata", mem_read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(A_STAT, 32'd1, "status_after_rst");
        idle(3);
        check("rd_sb_empty", rd_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
